// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int BAUD_W = 16;
  localparam int DEF_CLKS_PER_BIT = 434;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep synchroniser for the async serial line, resets to idle-high
//   clk, reset : system clock, sync active-high reset
//   i_async    : asynchronous input
//   o_sync     : synchronised output
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);
  logic [SYNC_STAGES-1:0] r_sync;
  always_ff @(posedge clk)
    r_sync <= reset ? '1 : {r_sync[SYNC_STAGES-2:0], i_async};
  assign o_sync = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling (even parity when UART_RX_PARITY_EN is defined)
//   clk, reset      : system clock, sync active-high reset
//   UART_rx_data_in : async serial line, idles high
//   rx_out          : last good byte, held until the next one
//   rx_valid        : 1-cycle strobe, rx_out updated
//   rx_busy         : receiver not idle
//   frame_err       : 1-cycle strobe, stop bit sampled low
//   parity_err      : 1-cycle strobe, parity mismatch (0 unless UART_RX_PARITY_EN)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 UART_rx_data_in,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);
  localparam logic [BAUD_W-1:0] FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  rx_state_e r_state, w_next;
  logic [BAUD_W-1:0] r_baud, w_baud;
  logic [BIT_W-1:0] r_bit, w_bit;
  logic [DATA_BITS-1:0] r_shift, w_shift, r_out, w_out;
  logic r_valid, w_valid, r_ferr, w_ferr;
  logic w_line, w_full, w_half;
`ifdef UART_RX_PARITY_EN
  logic r_par, w_par, r_perr, w_perr;
`endif
  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .i_async(UART_rx_data_in), .o_sync(w_line)
  );
  assign w_full = r_baud == FULL;
  assign w_half = r_baud == HALF;
  always_comb begin
    w_next = r_state;
    w_bit = r_bit;
    w_shift = r_shift;
    w_out = r_out;
    w_valid = 1'b0;
    w_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par = r_par;
    w_perr = 1'b0;
`endif
    case (r_state)
      IDLE: w_next = w_line ? IDLE : START;
      START: if (w_half) begin
        w_next = w_line ? IDLE : DATA;
        w_bit = '0;
      end
      DATA: if (w_full) begin
        w_shift = {w_line, r_shift[DATA_BITS-1:1]};
        w_bit = r_bit + BIT_W'(1);
`ifdef UART_RX_PARITY_EN
        if (r_bit == BIT_W'(DATA_BITS - 1)) w_next = PARITY;
`else
        if (r_bit == BIT_W'(DATA_BITS - 1)) w_next = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_full) begin
        w_par = w_line;
        w_next = STOP;
      end
`endif
      STOP: if (w_full) begin
        w_next = w_line ? IDLE : WAIT_HIGH;
        w_ferr = !w_line;
`ifdef UART_RX_PARITY_EN
        // even parity: data plus parity bit must hold an even number of ones
        w_perr = w_line && ^{r_shift, r_par};
        w_valid = w_line && !w_perr;
`else
        w_valid = w_line;
`endif
        w_out = w_valid ? r_shift : r_out;
      end
      WAIT_HIGH: w_next = w_line ? IDLE : WAIT_HIGH;
      default: w_next = IDLE;
    endcase
    // data bits re-arm the counter each period; any state change restarts it
    w_baud = (w_next != r_state || w_full) ? '0 : r_baud + BAUD_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_out <= '0;
      r_valid <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par <= 1'b0;
      r_perr <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_baud <= w_baud;
      r_bit <= w_bit;
      r_shift <= w_shift;
      r_out <= w_out;
      r_valid <= w_valid;
      r_ferr <= w_ferr;
`ifdef UART_RX_PARITY_EN
      r_par <= w_par;
      r_perr <= w_perr;
`endif
    end
  end
  assign rx_out = r_out;
  assign rx_valid = r_valid;
  assign frame_err = r_ferr;
  assign rx_busy = r_state != IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif
endmodule
